// File: rtl/serial_seq_pkg.sv
// Shared definitions for the serial sequence transmitter.
//   state_e  : 2-bit controller state encoding, exported on the y port
//   PREAMBLE : frame preamble bits, sent MSB first (used only when
//              SERIAL_SEQ_TX_PREAMBLE_EN is defined)
//   PRE_LEN  : number of preamble bits
package serial_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b11,
    ST_PRE   = 2'b10
  } state_e;

  localparam logic [2:0] PREAMBLE = 3'b110;
  localparam int         PRE_LEN  = 3;

endpackage

// File: rtl/serial_seq_tx.sv
// Serial sequence transmitter: accepts a parallel word over valid/ready and
// drives it MSB-first, one bit per clock, on the registered serial line w.
// Each frame is followed by GAP idle cycles (w=0) and one mandatory IDLE cycle.
//
// Build option: SERIAL_SEQ_TX_PREAMBLE_EN -- when defined, each frame is
// prefixed by the 3-bit preamble 1,1,0 sent from state PRE.
//
// Parameters:
//   DATA_W   bits per frame (>=2)
//   GAP      idle cycles after each frame (>=1)
// Ports:
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   in_valid   source has a word on in_data
//   in_data    word to transmit, sampled on handshake
//   in_ready   high only in IDLE (decoded from state only)
//   w          serial data line, registered
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the first GAP cycle of each frame
//   y          current state encoding
module serial_seq_tx
  import serial_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              w,
  output logic              busy,
  output logic              done,
  output logic [1:0]        y
);

  localparam int CNT_W = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_q, w_d;
  logic              done_q, done_d;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
  logic [2:0]        pre_bits;
`endif

  // Next-state logic. w and done are computed for the cycle that follows the
  // edge, so the first bit appears on w right after the accepting edge.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    w_d     = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
    pre_bits = 3'b000;
`endif
    case (state_q)
      ST_IDLE: begin
        // in_ready is 1 here, so in_valid alone is the handshake.
        if (in_valid) begin
          sr_d  = in_data;
          cnt_d = '0;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
          state_d = ST_PRE;
          w_d     = PREAMBLE[2];
`else
          state_d = ST_SHIFT;
          w_d     = in_data[DATA_W-1];
`endif
        end
      end
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          // The word was loaded at handshake; its MSB goes out next.
          state_d = ST_SHIFT;
          cnt_d   = '0;
          w_d     = sr_q[DATA_W-1];
        end else begin
          cnt_d    = cnt_q + 1'b1;
          // Preamble bit for the next cycle is PREAMBLE[2 - cnt_d].
          pre_bits = PREAMBLE << cnt_d;
          w_d      = pre_bits[2];
        end
      end
`endif
      ST_SHIFT: begin
        // sr_q[MSB] is the bit currently on w; shift it out, zero-fill.
        sr_d = {sr_q[DATA_W-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          w_d   = sr_q[DATA_W-2];
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign w        = w_q;
  assign done     = done_q;
  assign y        = state_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx: directed steps with a scoreboard of expected
// per-cycle {w, done, y} values for each accepted frame.
module tb_serial_seq_tx;

  localparam int DATA_W = 8;
  localparam int GAP    = 2;
`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
  localparam int PRE_CYC = 3;
`else
  localparam int PRE_CYC = 0;
`endif
  localparam int PERIOD = DATA_W + GAP + 1 + PRE_CYC;

  logic              clk;
  logic              resetn;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              w;
  logic              busy;
  logic              done;
  logic [1:0]        y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int z_count  = 0;
  logic prev_w = 1'b0;
  logic [3:0] sb[$];

  serial_seq_tx #(.DATA_W(DATA_W), .GAP(GAP)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .w        (w),
    .busy     (busy),
    .done     (done),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == n between edge n and edge n+1
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {w, done, y} for every busy cycle of one frame.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [2:0] pre;
    pre = 3'b110;
    for (int p = 0; p < PRE_CYC; p++) sb.push_back({pre[2-p], 1'b0, 2'b10});
    for (int j = 0; j < DATA_W; j++) sb.push_back({d[DATA_W-1-j], 1'b0, 2'b01});
    for (int g = 0; g < GAP; g++) sb.push_back({1'b0, (g == 0), 2'b11});
  endtask

  // Offer a word; returns the handshake edge number. Ends at the negedge of
  // the first cycle after the handshake.
  task automatic send(input logic [DATA_W-1:0] d, input bit hold, output int hs);
    hs = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      if (in_ready) begin
        hs = cyc + 1;
        push_frame(d);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 1000 && cyc < n; i++) @(negedge clk);
  endtask

  // Output monitor: frame cycles against the scoreboard, idle cycles quiet.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (resetn) begin
      if (busy) begin
        if (sb.size() == 0) begin
          chk("sb_empty_while_busy", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("frame_w_done_y", {28'd0, w, done, y}, {28'd0, e});
        end
      end else begin
        chk("idle_w", {31'd0, w}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_y", {30'd0, y}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
      end
    end
    // Run-of-ones detector on the looped-back line: one count per "11".
    if (prev_w && w) z_count <= z_count + 1;
    prev_w <= w;
  end

  initial begin : main
    int hs, hs1, hs2, z0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_w", {31'd0, w}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_y", {30'd0, y}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    #2 resetn = 1'b1;

    // Basic frame
    send(8'hA5, 1'b0, hs);
    chk("a5_first_bit", {31'd0, w}, 32'd1 ^ 32'(PRE_CYC == 3 ? 0 : 0));
    wait_cyc(hs + PRE_CYC + DATA_W);
    chk("a5_done", {31'd0, done}, 32'd1);
    wait_cyc(hs + PRE_CYC + DATA_W + GAP - 1);
    chk("a5_ready_low", {31'd0, in_ready}, 32'd0);
    wait_cyc(hs + PRE_CYC + DATA_W + GAP);
    chk("a5_ready_rise", {31'd0, in_ready}, 32'd1);

    // Back-to-back with in_valid held high
    send(8'hFF, 1'b1, hs1);
    send(8'h00, 1'b0, hs2);
    chk("b2b_period", 32'(hs2 - hs1), 32'(PERIOD));
    wait_cyc(hs2 + PRE_CYC + 3);
    chk("zero_busy", {31'd0, busy}, 32'd1);
    chk("zero_w", {31'd0, w}, 32'd0);
    wait_cyc(hs2 + PERIOD);

    // Back-pressure: offer during SHIFT is ignored
    send(8'h5A, 1'b0, hs);
    wait_cyc(hs + PRE_CYC + 2);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    send(8'h3C, 1'b0, hs1);
    chk("bp_accept_cycle", 32'(hs1 - hs), 32'(PERIOD));
    wait_cyc(hs1 + PERIOD);

    // Reset mid-frame during bit 4 of F0
    send(8'hF0, 1'b0, hs);
    wait_cyc(hs + PRE_CYC + 3);
    chk("f0_bit3", {31'd0, w}, 32'd1);
    wait_cyc(hs + PRE_CYC + 4);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_w", {31'd0, w}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_y", {30'd0, y}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (PERIOD) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef SERIAL_SEQ_TX_PREAMBLE_EN
    // Preamble frame
    send(8'h81, 1'b0, hs);
    chk("pre_y_first", {30'd0, y}, 32'd2);
    chk("pre_w_first", {31'd0, w}, 32'd1);
    wait_cyc(hs + 3);
    chk("pre_y_shift", {30'd0, y}, 32'd1);
    wait_cyc(hs + 11);
    chk("pre_done", {31'd0, done}, 32'd1);
    chk("pre_y_gap", {30'd0, y}, 32'd3);
    wait_cyc(hs + PERIOD);
`else
    // Loopback into a run-of-ones detector
    z0 = z_count;
    send(8'h60, 1'b0, hs);
    wait_cyc(hs + PERIOD);
    chk("loop_z_60", 32'(z_count - z0), 32'd1);
    z0 = z_count;
    send(8'h55, 1'b0, hs);
    wait_cyc(hs + PERIOD);
    chk("loop_z_55", 32'(z_count - z0), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
